// File: rtl/pipe_2c_arbiter_pkg.sv
// Shared types and constants for the 2-cycle pipe arbiter.
package pipe_2c_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } arb_state_e;

    localparam int unsigned PIPE_LAT = 2;
    localparam int unsigned CNT_W    = 4;

    // Index width for an n-way requester set; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_2c_arbiter_if.sv
// Requester, pipe and status signals of the shared 2-cycle pipe arbiter.
interface pipe_2c_arbiter_if
    import pipe_2c_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 3
);
    localparam int unsigned IW = id_width(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [DW-1:0]       pipe_in;
    logic [DW-1:0]       pipe_out;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                flush;
    logic [IW-1:0]       owner;
    logic [1:0]          inflight;
    logic                busy;

    modport master (
        output req_valid, req_data, pipe_out, flush,
        input  req_ready, pipe_in, rsp_valid, rsp_data, owner, inflight, busy
    );

    modport slave (
        input  req_valid, req_data, pipe_out, flush,
        output req_ready, pipe_in, rsp_valid, rsp_data, owner, inflight, busy
    );

endinterface

// File: rtl/pipe_2c_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: first set request at or after start, wrapping.
module rr_pick
    import pipe_2c_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);

    int unsigned c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = 32'(start) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && req[c]) begin
                found  = 1'b1;
                idx    = IW'(c);
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_2c_arbiter.sv
// Round-robin burst arbiter feeding a shared 2-cycle delay pipe, with a valid/ID
// shadow pipe that routes each result back to its requester.
module pipe_2c_arbiter
    import pipe_2c_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 3,
    parameter int unsigned BURST_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    pipe_2c_arbiter_if.slave bus
);

    localparam int unsigned IW = id_width(N_REQ);

    arb_state_e          state_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [PIPE_LAT-1:0] sh_v_q;
    logic [IW-1:0]       sh_id_q [PIPE_LAT];

    logic                grant_en;
    logic                owner_hold;
    logic [IW-1:0]       owner_next;
    logic [IW-1:0]       start;
    logic [N_REQ-1:0]    pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;
    logic [IW-1:0]       winner;
    logic                xfer;
    logic [N_REQ-1:0]    ready;
    logic [1:0]          inflight;

    assign grant_en   = (state_q != StDrain) && !bus.flush;
    assign owner_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_hold = (state_q == StBurst) && bus.req_valid[owner_q]
                        && (beat_cnt_q < CNT_W'(BURST_MAX));
    // In a burst the search starts after the owner, so the owner is checked last.
    assign start      = (state_q == StBurst) ? owner_next : rr_ptr_q;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (bus.req_valid),
        .start (start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        winner = owner_hold ? owner_q : pick_idx;
        xfer   = grant_en && (owner_hold || pick_found);
        ready  = '0;
        if (grant_en) begin
            if (owner_hold) begin
                ready[owner_q] = 1'b1;
            end else begin
                ready = pick_gnt;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.pipe_in   = xfer ? bus.req_data[winner*DW +: DW] : '0;

    always_comb begin
        bus.rsp_valid = '0;
        if (sh_v_q[PIPE_LAT-1]) begin
            bus.rsp_valid[sh_id_q[PIPE_LAT-1]] = 1'b1;
        end
    end

    // The delay pipe is never reset, so its output only counts under a shadow valid.
    assign bus.rsp_data = sh_v_q[PIPE_LAT-1] ? bus.pipe_out : '0;
    assign inflight     = 2'($countones(sh_v_q));
    assign bus.inflight = inflight;
    assign bus.busy     = (state_q != StIdle) || (inflight != 2'd0);
    assign bus.owner    = owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            sh_v_q     <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                sh_id_q[k] <= '0;
            end
        end else begin
            sh_v_q     <= {sh_v_q[PIPE_LAT-2:0], xfer};
            sh_id_q[0] <= winner;
            for (int k = 1; k < PIPE_LAT; k++) begin
                sh_id_q[k] <= sh_id_q[k-1];
            end

            case (state_q)
                StIdle: begin
                    if (bus.flush) begin
                        state_q <= StDrain;
                    end else if (xfer) begin
                        state_q    <= StBurst;
                        owner_q    <= winner;
                        beat_cnt_q <= CNT_W'(1);
                    end
                end
                StBurst: begin
                    if (bus.flush) begin
                        state_q <= StDrain;
                    end else if (xfer) begin
                        if (winner == owner_q) begin
                            beat_cnt_q <= (beat_cnt_q >= CNT_W'(BURST_MAX)) ?
                                          CNT_W'(1) : beat_cnt_q + 1'b1;
                        end else begin
                            owner_q    <= winner;
                            beat_cnt_q <= CNT_W'(1);
                        end
                    end else begin
                        state_q  <= StIdle;
                        rr_ptr_q <= owner_next;
                    end
                end
                StDrain: begin
                    if (!bus.flush && (inflight == 2'd0)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_2c_arbiter.sv
// Directed plus random stimulus checked against a transaction-level arbiter model.
module tb_pipe_2c_arbiter;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_2c_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    pipe_2c_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .BURST_MAX (BM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External 2-cycle delay register, no reset.
    logic [DW-1:0] dly1, dly2;
    always @(posedge clk) begin
        dly1 <= bus.pipe_in;
        dly2 <= dly1;
    end
    assign bus.pipe_out = dly2;

    int total = 0;
    int bad   = 0;

    // Model: ownership/run length, round-robin pointer, drain flag, in-flight list.
    bit m_known = 0;
    bit m_has_owner, m_drain;
    int m_owner, m_run, m_rr;
    bit exp_v  [2];
    int exp_id [2];
    int exp_d  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant(input logic [N-1:0] v, input bit fl);
        int start;
        if (m_drain || fl) return -1;
        if (m_has_owner && v[m_owner] && m_run < BM) return m_owner;
        start = m_has_owner ? (m_owner + 1) % N : m_rr;
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] pack(input int d0, input int d1, input int d2,
                                             input int d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit fl,
                        input bit r, input int want_rdy);
        int g, infl, pd;
        logic [N*DW-1:0] sh;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.flush     = fl;
        rst           = r;
        #1;
        g    = m_grant(v, fl);
        infl = int'(exp_v[0]) + int'(exp_v[1]);
        sh   = (g < 0) ? '0 : d >> (g * DW);
        pd   = int'(sh[DW-1:0]);
        if (m_known) begin
            chk("req_ready", 32'(bus.req_ready), (g < 0) ? 0 : (1 << g));
            chk("pipe_in", 32'(bus.pipe_in), pd);
            chk("rsp_valid", 32'(bus.rsp_valid), exp_v[1] ? (1 << exp_id[1]) : 0);
            chk("rsp_data", 32'(bus.rsp_data), exp_v[1] ? exp_d[1] : 0);
            chk("inflight", 32'(bus.inflight), infl);
            chk("busy", 32'(bus.busy), 32'(m_has_owner || m_drain || infl != 0));
            chk("owner", 32'(bus.owner), m_owner);
        end
        if (want_rdy >= 0) chk("directed_ready", 32'(bus.req_ready), want_rdy);
        if (r) begin
            m_known = 1; m_has_owner = 0; m_drain = 0;
            m_owner = 0; m_run = 0; m_rr = 0;
            exp_v[0] = 0; exp_v[1] = 0;
        end else begin
            exp_v[1] = exp_v[0]; exp_id[1] = exp_id[0]; exp_d[1] = exp_d[0];
            exp_v[0] = (g >= 0); exp_id[0] = (g >= 0) ? g : 0; exp_d[0] = pd;
            if (fl) begin
                m_drain = 1; m_has_owner = 0;
            end else if (m_drain) begin
                if (infl == 0) m_drain = 0;
            end else if (g >= 0) begin
                if (m_has_owner && g == m_owner) begin
                    m_run = (m_run >= BM) ? 1 : m_run + 1;
                end else begin
                    m_owner = g; m_run = 1;
                end
                m_has_owner = 1;
            end else if (m_has_owner) begin
                m_has_owner = 0;
                m_rr = (m_owner + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fl_left;
        logic [N-1:0] v;
        bit fl, r;
        fl_left = 0;
        rst = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.flush = 1'b0;

        step('0, '0, 0, 1, -1);
        step('0, '0, 0, 1, -1);
        step('0, '0, 0, 0, 0);

        // Single requester 2 streams 5,1,6.
        step(4'b0100, pack(0, 0, 5, 0), 0, 0, 4'b0100);
        step(4'b0100, pack(0, 0, 1, 0), 0, 0, 4'b0100);
        step(4'b0100, pack(0, 0, 6, 0), 0, 0, 4'b0100);
        repeat (3) step('0, '0, 0, 0, -1);

        // All four requesters saturating: bursts of BM rotate.
        for (int i = 0; i < 20; i++) step(4'b1111, pack(i, i + 1, i + 2, i + 3), 0, 0, -1);
        repeat (2) step('0, '0, 0, 0, -1);

        // Requester 1 drops mid-burst, then 3 beats 1 from rr_ptr = 2.
        step(4'b0010, pack(0, 2, 0, 0), 0, 0, 4'b0010);
        step(4'b0010, pack(0, 3, 0, 0), 0, 0, 4'b0010);
        step('0, '0, 0, 0, -1);
        step(4'b1010, pack(0, 4, 0, 7), 0, 0, 4'b1000);
        repeat (3) step('0, '0, 0, 0, -1);

        // Flush after two transfers; results still delivered.
        step(4'b0001, pack(3, 0, 0, 0), 0, 0, -1);
        step(4'b0001, pack(4, 0, 0, 0), 0, 0, -1);
        repeat (4) step(4'b1111, pack(1, 2, 3, 4), 1, 0, 0);
        repeat (3) step('0, '0, 0, 0, -1);

        // Reset with two beats of 7 in flight.
        step(4'b0001, pack(7, 0, 0, 0), 0, 0, -1);
        step(4'b0001, pack(7, 0, 0, 0), 0, 0, -1);
        step('0, '0, 0, 1, -1);
        step('0, '0, 0, 0, -1);
        chk("post_rst_busy", 32'(bus.busy), 0);

        // Lone owner beyond BM: no bubbles.
        for (int i = 0; i < 10; i++) step(4'b0001, pack(i, 0, 0, 0), 0, 0, 4'b0001);
        repeat (3) step('0, '0, 0, 0, -1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            if (fl_left > 0) begin
                fl = 1; fl_left--;
            end else begin
                fl = 0;
                if ($urandom_range(0, 24) == 0) fl_left = $urandom_range(1, 4);
            end
            r = ($urandom_range(0, 99) == 0);
            step(v, (N * DW)'($urandom), fl, r, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
